// File: rtl/mo_mul_arb.sv
// Round-robin front end that shares one external mo_mul pipeline between N_REQ requesters,
// tags each issued operation with its owner and routes the result back; supports flush/drain.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module mo_mul_arb #(
    parameter int N_REQ = 2,
    parameter int LAT   = `DATA_WIDTH + 2,
    parameter int DW    = `DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0][DW-1:0]  req_a,
    input  logic [N_REQ-1:0][DW-1:0]  req_b,
    input  logic                      flush,
    output logic                      flush_done,
    output logic [DW-1:0]             mul_a,
    output logic [DW-1:0]             mul_b,
    input  logic [DW-1:0]             mul_result,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [DW-1:0]             resp_data,
    output logic                      busy,
    output logic [1:0]                state
);

    // Handshake: a requester holds req_valid and its operands until req_ready is seen;
    // req_ready is a pure grant, so req_valid & req_ready in a cycle is one accept.

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [IW-1:0] rr;
    logic [IW-1:0] grant_id;
    logic          grant_any;
    logic [LAT:0]  sr_valid;
    logic [IW-1:0] sr_id [0:LAT];

    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        if (state == ST_RUN && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = idx[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            rr       <= '0;
            sr_valid <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            for (int k = 0; k <= LAT; k++) sr_id[k] <= '0;
        end else begin
            mul_a    <= grant_any ? req_a[grant_id] : '0;
            mul_b    <= grant_any ? req_b[grant_id] : '0;
            // Ownership tag travels alongside the operation; slot LAT lines up with mul_result.
            sr_valid <= {sr_valid[LAT-1:0], grant_any};
            sr_id[0] <= grant_id;
            for (int k = 1; k <= LAT; k++) sr_id[k] <= sr_id[k-1];
            if (grant_any) rr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            case (state)
                ST_RUN:   if (flush) state <= ST_DRAIN;
                ST_DRAIN: if (!busy) state <= ST_DONE;
                ST_DONE:  if (!flush) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign busy       = |sr_valid;
    assign flush_done = (state == ST_DONE) && !rst;
    assign resp_data  = sr_valid[LAT] ? mul_result : '0;

    always_comb begin
        resp_valid = '0;
        if (sr_valid[LAT]) resp_valid[sr_id[LAT]] = 1'b1;
    end

endmodule

// File: tb/tb_mo_mul_arb.sv
// Bench for mo_mul_arb: a bit-serial Montgomery model stands in for the external mo_mul,
// and a queue of expected responses is filled from a high-level round-robin model.
module tb_mo_mul_arb;

    localparam int N   = 2;
    localparam int DW  = 12;
    localparam int LAT = DW + 2;
    localparam int Q   = 3329;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][DW-1:0] req_a = '0;
    logic [N-1:0][DW-1:0] req_b = '0;
    logic                 flush = 1'b0;
    logic                 flush_done;
    logic [DW-1:0]        mul_a, mul_b, mul_result;
    logic [N-1:0]         resp_valid;
    logic [DW-1:0]        resp_data;
    logic                 busy;
    logic [1:0]           state;

    mo_mul_arb #(.N_REQ(N), .LAT(LAT), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .flush(flush), .flush_done(flush_done),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy), .state(state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external mo_mul model ----------------
    function automatic logic [DW-1:0] mont_serial(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int u;
        u = 0;
        for (int i = 0; i < DW; i++) begin
            if (a[i]) u = u + int'(b);
            if (u[0]) u = u + Q;
            u = u >> 1;
        end
        if (u >= Q) u = u - Q;
        return u[DW-1:0];
    endfunction

    logic [DW-1:0] mpipe [0:LAT-1];
    initial for (int k = 0; k < LAT; k++) mpipe[k] = '0;
    always @(posedge clk) begin
        mpipe[0] <= mont_serial(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[LAT-1];

    // ---------------- reference model ----------------
    int rinv = 0;
    function automatic logic [DW-1:0] golden(input int a, input int b);
        longint p;
        p = (longint'(a) * longint'(b)) % Q;
        p = (p * longint'(rinv)) % Q;
        return p[DW-1:0];
    endfunction

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t          exp_q[$];
    int            m_rr  = 0;
    bit            m_run = 1'b1;
    logic [DW-1:0] cur_a [N];
    logic [DW-1:0] cur_b [N];

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    logic          sb_busy;
    logic [DW-1:0] sb_ma, sb_mb;
    logic [N-1:0]  sb_rv;
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            sb_busy = 1'b0;
            sb_ma   = '0;
            sb_mb   = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].due - LAT <= cyc && cyc <= exp_q[i].due) sb_busy = 1'b1;
                if (exp_q[i].due == cyc + LAT) begin
                    sb_ma = exp_q[i].a;
                    sb_mb = exp_q[i].b;
                end
            end
            checks++;
            if (busy !== sb_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, sb_busy);
            end
            checks++;
            if (mul_a !== sb_ma || mul_b !== sb_mb) begin
                errors++;
                $display("FAIL mul_operands cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, mul_a, mul_b, sb_ma, sb_mb);
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                errors++;
                $display("FAIL missed_resp due=%0d id=%0d", exp_q[0].due, exp_q[0].id);
                void'(exp_q.pop_front());
            end
            checks++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                sb_rv = '0;
                sb_rv[exp_q[0].id] = 1'b1;
                if (resp_valid !== sb_rv || resp_data !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL resp cyc=%0d got=%b/%0d exp=%b/%0d", cyc, resp_valid, resp_data, sb_rv, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else if (resp_valid !== '0 || resp_data !== '0) begin
                errors++;
                $display("FAIL idle_resp cyc=%0d got=%b/%0d exp=0/0", cyc, resp_valid, resp_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] v, input logic fl, output logic [N-1:0] er, output int g);
        int   idx;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        flush     = fl;
        for (int i = 0; i < N; i++) begin
            req_a[i] = cur_a[i];
            req_b[i] = cur_b[i];
        end
        #1;
        g = -1;
        if (m_run) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) begin
            er[g]  = 1'b1;
            e.due  = cyc + LAT + 1;
            e.id   = g;
            e.data = golden(int'(cur_a[g]), int'(cur_b[g]));
            e.a    = cur_a[g];
            e.b    = cur_b[g];
            exp_q.push_back(e);
            m_rr     = (g + 1) % N;
            cur_a[g] = DW'($urandom_range(0, Q - 1));
            cur_b[g] = DW'($urandom_range(0, Q - 1));
        end
    endtask

    task automatic idle(input int n);
        logic [N-1:0] er;
        int           g;
        repeat (n) drive('0, 1'b0, er, g);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        req_valid = '1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        checks++;
        if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
        checks++;
        if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("FAIL reset_mul got=%0d,%0d exp=0,0", mul_a, mul_b); end
        checks++;
        if (resp_valid !== '0 || resp_data !== '0) begin errors++; $display("FAIL reset_resp got=%b/%0d exp=0/0", resp_valid, resp_data); end
        checks++;
        if (busy !== 1'b0 || state !== S_RUN) begin errors++; $display("FAIL reset_state got=%b/%0d exp=0/%0d", busy, state, S_RUN); end
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_rr = 0;
        m_run = 1'b1;
    endtask

    task automatic test_single;
        logic [N-1:0] er;
        int           g;
        cur_a[0] = 12'd767;
        cur_b[0] = 12'd5;
        drive(2'b01, 1'b0, er, g);
        checks++;
        if (req_ready !== 2'b01 || er !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", req_ready); end
        checks++;
        if (exp_q[exp_q.size()-1].data !== 12'd5) begin errors++; $display("FAIL single_golden got=%0d exp=5", exp_q[exp_q.size()-1].data); end
        idle(LAT + 3);
    endtask

    task automatic test_req1_only;
        logic [N-1:0] er;
        int           g;
        for (int k = 0; k < 3; k++) begin
            drive(2'b10, 1'b0, er, g);
            checks++;
            if (req_ready !== er) begin errors++; $display("FAIL req1_grant k=%0d got=%b exp=%b", k, req_ready, er); end
        end
        idle(2);
    endtask

    task automatic test_alternate;
        logic [N-1:0] er;
        int           g;
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 1'b0, er, g);
            checks++;
            if (req_ready !== er || g != (k % 2)) begin errors++; $display("FAIL alt_grant k=%0d got=%b exp=%b", k, req_ready, er); end
        end
        idle(LAT + 3);
    endtask

    task automatic test_random;
        logic [N-1:0] er;
        logic [N-1:0] pend;
        int           g;
        pend = '0;
        for (int c = 0; c < 150 + N; c++) begin
            if (c < 150)
                for (int i = 0; i < N; i++) if (!pend[i]) pend[i] = 1'($urandom_range(0, 1));
            drive(pend, 1'b0, er, g);
            checks++;
            if (req_ready !== er) begin errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, er); end
            if (g >= 0) pend[g] = 1'b0;
        end
        idle(LAT + 3);
    endtask

    task automatic test_flush;
        logic [N-1:0] er;
        int           g;
        int           r;
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 1'b0, er, g);
            checks++;
            if (req_ready !== er) begin errors++; $display("FAIL flush_issue k=%0d got=%b exp=%b", k, req_ready, er); end
        end
        drive(2'b01, 1'b1, er, g);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_cycle_grant got=%b exp=01", req_ready); end
        r = cyc + LAT + 1;
        m_run = 1'b0;
        while (cyc < r + 4) begin
            drive(2'b11, 1'b1, er, g);
            checks++;
            if (req_ready !== '0) begin errors++; $display("FAIL drain_grant cyc=%0d got=%b exp=00", cyc, req_ready); end
            checks++;
            if (flush_done !== (cyc >= r + 2) || state !== ((cyc >= r + 2) ? S_DONE : S_DRAIN)) begin
                errors++;
                $display("FAIL drain_state cyc=%0d got=%b/%0d last_resp=%0d", cyc, flush_done, state, r);
            end
        end
        drive('0, 1'b0, er, g);
        checks++;
        if (flush_done !== 1'b1) begin errors++; $display("FAIL done_hold got=%b exp=1", flush_done); end
        m_run = 1'b1;
        drive('0, 1'b0, er, g);
        checks++;
        if (flush_done !== 1'b0 || state !== S_RUN) begin errors++; $display("FAIL done_exit got=%b/%0d exp=0/%0d", flush_done, state, S_RUN); end
        idle(2);
    endtask

    task automatic test_flush_empty;
        logic [N-1:0] er;
        int           g;
        drive('0, 1'b1, er, g);
        checks++;
        if (state !== S_RUN || flush_done !== 1'b0) begin errors++; $display("FAIL empty_f0 got=%0d/%b exp=%0d/0", state, flush_done, S_RUN); end
        m_run = 1'b0;
        drive(2'b11, 1'b1, er, g);
        checks++;
        if (state !== S_DRAIN || flush_done !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL empty_f1 got=%0d/%b/%b exp=%0d/0/00", state, flush_done, req_ready, S_DRAIN);
        end
        drive(2'b11, 1'b1, er, g);
        checks++;
        if (state !== S_DONE || flush_done !== 1'b1 || req_ready !== '0) begin
            errors++; $display("FAIL empty_f2 got=%0d/%b/%b exp=%0d/1/00", state, flush_done, req_ready, S_DONE);
        end
        drive('0, 1'b0, er, g);
        m_run = 1'b1;
        drive('0, 1'b0, er, g);
        checks++;
        if (state !== S_RUN) begin errors++; $display("FAIL empty_exit got=%0d exp=%0d", state, S_RUN); end
    endtask

    task automatic test_reset_inflight;
        logic [N-1:0] er;
        int           g;
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, 1'b0, er, g);
            checks++;
            if (req_ready !== er) begin errors++; $display("FAIL inflight_issue k=%0d got=%b exp=%b", k, req_ready, er); end
        end
        #2;
        req_valid = '0;
        rst = 1'b1;
        exp_q.delete();
        m_rr = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL async_reset got=%b/%b/%b exp=0/00/00", busy, resp_valid, req_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(2'b01, 1'b0, er, g);
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_grant got=%b exp=01", req_ready); end
        idle(LAT + 6);
    endtask

    initial begin
        for (int x = 1; x < Q; x++) if ((x * 4096) % Q == 1) rinv = x;
        for (int i = 0; i < N; i++) begin
            cur_a[i] = DW'($urandom_range(0, Q - 1));
            cur_b[i] = DW'($urandom_range(0, Q - 1));
        end
        test_reset();
        test_single();
        test_req1_only();
        test_alternate();
        test_random();
        test_flush();
        test_flush_empty();
        test_reset_inflight();
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_exp got=%0d exp=0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
